// File: rtl/mid_ctrl.sv
// mid_ctrl: fault-simulation campaign controller.
//   For every injected fault, applies PATS patterns from the pattern generator
//   to a faulty CUT and a fault-free CUT. It compares their outputs and counts
//   evaluated and detected faults, then steps the fault injection logic.
//
// Optional build macro: MID_CTRL_FAULT_DROP_EN
//   When defined, the first valid mismatch for a fault ends pattern
//   application for that fault early (fault dropping).
//
// Parameters:
//   IN_BITS  - pattern width
//   OUT_BITS - CUT output width
//   PATS     - patterns per fault (1..65535)
//   CNT_W    - width of fault_cnt / det_cnt (saturating)
//
// Ports:
//   clk, rst         - clock; synchronous active-low reset
//   start            - begins a campaign (sampled in IDLE and DONE)
//   TPG_IP / TPG_EN  - pattern generator data in / advance strobe out
//   TEST_IP          - registered pattern driven to both CUTs
//   CUT_OP / FF_OP   - faulty / fault-free CUT outputs
//   FIL_INC/FIL_END  - step to the next fault / last fault is injected
//   busy, done       - campaign running / campaign finished
//   fault_cnt        - number of faults evaluated
//   det_cnt          - number of faults detected
module mid_ctrl #(
  parameter int unsigned IN_BITS  = 1,
  parameter int unsigned OUT_BITS = 1,
  parameter int unsigned PATS     = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IN_BITS-1:0]  TPG_IP,
  output logic                TPG_EN,
  output logic [IN_BITS-1:0]  TEST_IP,
  input  logic [OUT_BITS-1:0] CUT_OP,
  input  logic [OUT_BITS-1:0] FF_OP,
  output logic                FIL_INC,
  input  logic                FIL_END,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    fault_cnt,
  output logic [CNT_W-1:0]    det_cnt
);

  typedef enum logic [2:0] {IDLE, APPLY, DRAIN, NEXT, DONE} state_t;

  localparam logic [15:0]      PAT_LAST = 16'(PATS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t      state, state_nxt;
  logic [15:0] pat_cnt;
  logic        drain_cnt;
  logic        test_valid;  // TEST_IP was loaded for the current fault last edge
  logic        mismatch;    // registered compare result
  logic        mis_valid;   // mismatch belongs to a pattern of the current fault
  logic        det_flag;
  logic        cmp_hit;
  logic        launch;

  assign cmp_hit = |(CUT_OP ^ FF_OP);

  always_comb begin
    state_nxt = state;
    TPG_EN    = 1'b0;
    FIL_INC   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    launch    = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          launch    = 1'b1;
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        TPG_EN = 1'b1;
        busy   = 1'b1;
        if (pat_cnt == PAT_LAST) state_nxt = DRAIN;
`ifdef MID_CTRL_FAULT_DROP_EN
        // Drop on the live compare so the generator stops right after the
        // detecting pattern; the register/flag path still records it in DRAIN.
        if (test_valid && cmp_hit) state_nxt = DRAIN;
`endif
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt) state_nxt = NEXT;
      end
      NEXT: begin
        busy = 1'b1;
        if (FIL_END) begin
          state_nxt = DONE;
        end else begin
          FIL_INC   = 1'b1;
          state_nxt = APPLY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      TEST_IP    <= '0;
      pat_cnt    <= '0;
      drain_cnt  <= 1'b0;
      test_valid <= 1'b0;
      mismatch   <= 1'b0;
      mis_valid  <= 1'b0;
      det_flag   <= 1'b0;
      fault_cnt  <= '0;
      det_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      test_valid <= (state == APPLY);
      mismatch   <= cmp_hit;
      mis_valid  <= test_valid;
      drain_cnt  <= (state == DRAIN) ? ~drain_cnt : 1'b0;

      if (state == APPLY) begin
        TEST_IP <= TPG_IP;
        pat_cnt <= pat_cnt + 16'd1;
      end

      if (launch) begin
        pat_cnt   <= '0;
        det_flag  <= 1'b0;
        fault_cnt <= '0;
        det_cnt   <= '0;
      end else if (state == NEXT) begin
        // The pipeline is empty by NEXT, so the flag is final here.
        pat_cnt  <= '0;
        det_flag <= 1'b0;
        if (fault_cnt != CNT_MAX) fault_cnt <= fault_cnt + CNT_W'(1);
        if (det_flag && (det_cnt != CNT_MAX)) det_cnt <= det_cnt + CNT_W'(1);
      end else if (mismatch && mis_valid) begin
        det_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mid_ctrl.sv
// tb_mid_ctrl: self-checking bench for mid_ctrl.
//   Two DUT instances (PATS=4/CNT_W=16 and PATS=1/CNT_W=3) share one
//   environment: a counting pattern generator, a fault index, and a CUT pair
//   whose faulty copy flips outputs for (fault, pattern) entries in a table.
//   Expected results come from a per-fault walk over that table.
module tb_mid_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  bit          sel;            // 0: dut4, 1: dut1
  logic [7:0]  tpg_ip, test_ip4, test_ip1, test_ip;
  logic [2:0]  cut_op, ff_op;
  logic        tpg_en4, tpg_en1, fil_inc4, fil_inc1;
  logic        busy4, busy1, done4, done1, fil_end;
  logic [15:0] fc4, dc4;
  logic [2:0]  fc1, dc1;
  logic        start4, start1;
  logic        tpg_en_s, fil_inc_s, busy_s, done_s;
  logic [15:0] fc_s, dc_s;

  int   ptr, fidx, en_cnt, inc_cnt, nfaults;
  logic env_clr;
  bit   det_tab [16][256];

  int checks = 0;
  int errors = 0;

  function automatic logic [2:0] good(input logic [7:0] v);
    return v[2:0] ^ v[5:3] ^ {1'b0, v[7:6]};
  endfunction

  function automatic logic [2:0] flip(input logic [7:0] v);
    int r;
    r = int'(v) % 3;
    return (r == 0) ? 3'b001 : (r == 1) ? 3'b010 : 3'b100;
  endfunction

  assign start4    = start & ~sel;
  assign start1    = start & sel;
  assign test_ip   = sel ? test_ip1 : test_ip4;
  assign tpg_en_s  = sel ? tpg_en1 : tpg_en4;
  assign fil_inc_s = sel ? fil_inc1 : fil_inc4;
  assign busy_s    = sel ? busy1 : busy4;
  assign done_s    = sel ? done1 : done4;
  assign fc_s      = sel ? 16'(fc1) : fc4;
  assign dc_s      = sel ? 16'(dc1) : dc4;

  assign tpg_ip  = 8'(ptr);
  assign fil_end = (fidx == nfaults - 1);
  assign ff_op   = good(test_ip);
  assign cut_op  = ff_op ^ (((fidx < 16) && det_tab[fidx][test_ip]) ? flip(test_ip) : 3'b000);

  always @(posedge clk) begin
    if (env_clr) begin
      ptr <= 0; fidx <= 0; en_cnt <= 0; inc_cnt <= 0;
    end else begin
      if (tpg_en_s)  begin ptr  <= ptr + 1;  en_cnt  <= en_cnt + 1;  end
      if (fil_inc_s) begin fidx <= fidx + 1; inc_cnt <= inc_cnt + 1; end
    end
  end

  mid_ctrl #(.IN_BITS(8), .OUT_BITS(3), .PATS(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .TPG_IP(tpg_ip), .TPG_EN(tpg_en4),
    .TEST_IP(test_ip4), .CUT_OP(cut_op), .FF_OP(ff_op), .FIL_INC(fil_inc4),
    .FIL_END(fil_end), .busy(busy4), .done(done4), .fault_cnt(fc4), .det_cnt(dc4)
  );

  mid_ctrl #(.IN_BITS(8), .OUT_BITS(3), .PATS(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .TPG_IP(tpg_ip), .TPG_EN(tpg_en1),
    .TEST_IP(test_ip1), .CUT_OP(cut_op), .FF_OP(ff_op), .FIL_INC(fil_inc1),
    .FIL_END(fil_end), .busy(busy1), .done(done1), .fault_cnt(fc1), .det_cnt(dc1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_tab();
    for (int f = 0; f < 16; f++)
      for (int v = 0; v < 256; v++) det_tab[f][v] = 1'b0;
  endtask

  // Walk the faults in order: each fault consumes a contiguous run of
  // generator patterns; it is detected if any applied pattern is in its table.
  task automatic model(input bit s, output int efc, output int edc,
                       output int een, output int einc);
    int pats, maxc, p, first, len;
    pats = s ? 1 : 4;
    maxc = s ? 7 : 65535;
    p = 0; efc = 0; edc = 0; een = 0;
    for (int f = 0; f < nfaults; f++) begin
      first = 0;
      for (int k = 1; k <= pats; k++)
        if (first == 0 && det_tab[f][(p + k - 1) % 256]) first = k;
      len = pats;
`ifdef MID_CTRL_FAULT_DROP_EN
      if (first != 0 && first + 1 < len) len = first + 1;
`endif
      p   += len;
      een += len;
      if (efc < maxc) efc++;
      if (first != 0 && edc < maxc) edc++;
    end
    einc = nfaults - 1;
  endtask

  task automatic env_reset();
    env_clr = 1'b1;
    @(negedge clk);
    env_clr = 1'b0;
  endtask

  task automatic run_campaign(input bit s, input string name);
    int efc, edc, een, einc;
    bit got;
    sel = s;
    env_reset();
    model(s, efc, edc, een, einc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_after_start"}, 32'(busy_s), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      if (done_s) got = 1'b1;
    end
    check({name, "_done_reached"}, 32'(got), 32'd1);
    check({name, "_fault_cnt"}, 32'(fc_s), 32'(efc));
    check({name, "_det_cnt"}, 32'(dc_s), 32'(edc));
    check({name, "_tpg_en_cycles"}, 32'(en_cnt), 32'(een));
    check({name, "_fil_inc_pulses"}, 32'(inc_cnt), 32'(einc));
    check({name, "_busy_in_done"}, 32'(busy_s), 32'd0);
  endtask

  initial begin
    bit found;
    rst = 1'b0; start = 1'b0; sel = 1'b0; env_clr = 1'b1; nfaults = 1;
    clear_tab();
    repeat (3) @(negedge clk);
    check("rst_test_ip", 32'(test_ip4), 32'd0);
    check("rst_tpg_en", 32'(tpg_en4), 32'd0);
    check("rst_fil_inc", 32'(fil_inc4), 32'd0);
    check("rst_busy", 32'(busy4 | busy1), 32'd0);
    check("rst_done", 32'(done4 | done1), 32'd0);
    check("rst_fault_cnt", 32'(fc4), 32'd0);
    check("rst_det_cnt", 32'(dc4), 32'd0);
    rst = 1'b1;
    env_clr = 1'b0;
    @(negedge clk);

    // Three faults, no mismatches
    clear_tab(); nfaults = 3;
    run_campaign(1'b0, "p4_clean");
    check("p4_clean_done", 32'(done4), 32'd1);

    // Mismatch only on pattern 4 of fault 2 (generator index 7); restart from DONE
    clear_tab(); nfaults = 3; det_tab[1][7] = 1'b1;
    run_campaign(1'b0, "p4_last_pat");

    // Mismatch on pattern 2 of fault 2 (index 5): dropped early when enabled
    clear_tab(); nfaults = 3; det_tab[1][5] = 1'b1;
    run_campaign(1'b0, "p4_pat2");

    // PATS=1, five faults, all mismatching
    clear_tab(); nfaults = 5;
    for (int f = 0; f < 16; f++)
      for (int v = 0; v < 256; v++) det_tab[f][v] = 1'b1;
    run_campaign(1'b1, "p1_all5");

    // PATS=1, CNT_W=3, ten faults all detected: both counters saturate at 7
    nfaults = 10;
    run_campaign(1'b1, "p1_sat");

    // Reset during APPLY of fault 2
    clear_tab(); nfaults = 3; sel = 1'b0;
    env_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (fidx == 1 && tpg_en4) found = 1'b1;
      else @(negedge clk);
    end
    check("abort_reached_fault2", 32'(found), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_test_ip", 32'(test_ip4), 32'd0);
    check("abort_tpg_en", 32'(tpg_en4), 32'd0);
    check("abort_fil_inc", 32'(fil_inc4), 32'd0);
    check("abort_busy", 32'(busy4), 32'd0);
    check("abort_done", 32'(done4), 32'd0);
    check("abort_fault_cnt", 32'(fc4), 32'd0);
    check("abort_det_cnt", 32'(dc4), 32'd0);
    check("abort_fil_inc_total", 32'(inc_cnt), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    run_campaign(1'b0, "after_abort");

    // Randomized campaigns on both instances
    for (int r = 0; r < 10; r++) begin
      int thr;
      bit s;
      s = bit'(r % 2);
      nfaults = s ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 8));
      thr = int'($urandom_range(0, 40));
      for (int f = 0; f < 16; f++)
        for (int v = 0; v < 256; v++)
          det_tab[f][v] = (int'($urandom_range(0, 99)) < thr);
      run_campaign(s, s ? "rand_p1" : "rand_p4");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mid_ctrl.md
MID_CTRL -- requirements
Module: mid_ctrl

Interface
REQ-001 Parameter IN_BITS, default 1: test-pattern width.
REQ-002 Parameter OUT_BITS, default 1: CUT output width.
REQ-003 Parameter PATS, default 16: patterns applied per injected fault; legal range 1..65535.
REQ-004 Parameter CNT_W, default 16: width of the fault and detection counters.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-low.
REQ-007 start  in  1  starts a fault campaign; level-sampled in IDLE and DONE.
REQ-008 TPG_IP  in  IN_BITS  pattern from the test pattern generator.
REQ-009 TPG_EN  out  1  advances the pattern generator by one pattern.
REQ-010 TEST_IP  out  IN_BITS  registered pattern driven to both the faulty CUT and the fault-free CUT.
REQ-011 CUT_OP  in  OUT_BITS  output of the faulty CUT.
REQ-012 FF_OP  in  OUT_BITS  output of the fault-free CUT.
REQ-013 FIL_INC  out  1  one-cycle pulse that makes the fault injection logic step to the next fault.
REQ-014 FIL_END  in  1  high while the last fault is injected.
REQ-015 busy  out  1  high from campaign start until DONE is reached.
REQ-016 done  out  1  high while in DONE.
REQ-017 fault_cnt  out  CNT_W  number of faults evaluated.
REQ-018 det_cnt  out  CNT_W  number of faults detected.

Function
REQ-019 States: IDLE, APPLY, DRAIN, NEXT, DONE; reset enters IDLE.
REQ-020 IDLE: start=1 clears fault_cnt, det_cnt, pattern counter and sticky detect flag, then moves to APPLY.
REQ-021 APPLY: TPG_EN=1 every cycle; TEST_IP<=TPG_IP every cycle; pattern counter increments; after PATS patterns the state moves to DRAIN.
REQ-022 Compare stage: mismatch register <= OR-reduce(CUT_OP XOR FF_OP), sampled one cycle after TEST_IP updates; the total latency from TPG_EN to a valid mismatch is 2 cycles.
REQ-023 Sticky detect flag is set by any valid mismatch belonging to the current fault; a compare is valid only in the 2 cycles following each TEST_IP update for that fault.
REQ-024 DRAIN: TPG_EN=0; the state is held for exactly 2 cycles so the last pattern's compare is counted, then moves to NEXT.
REQ-025 NEXT (1 cycle): fault_cnt+1; det_cnt+1 if the flag is set; both counters saturate at 2^CNT_W-1.
REQ-026 NEXT exit: if FIL_END=1 go to DONE; otherwise pulse FIL_INC for this single cycle, clear the flag and pattern counter, and go to APPLY.
REQ-027 FIL_INC is never asserted outside NEXT, and never more than 1 cycle per fault.
REQ-028 DONE: counters are held and done=1; start=1 behaves as it does in IDLE (new campaign); the fault injection logic is not rewound by this block.
REQ-029 PATS=1: APPLY lasts 1 cycle; the rest of the flow is unchanged.
REQ-030 start is ignored in APPLY, DRAIN and NEXT.

Reset
REQ-031 With rst=0 at a clock edge: state=IDLE, and TEST_IP, TPG_EN, FIL_INC, busy, done, fault_cnt, det_cnt, mismatch register and flag are all 0.
REQ-032 Reset mid-campaign aborts immediately, with no FIL_INC pulse and no counter update.

Configuration
REQ-033 Macro MID_CTRL_FAULT_DROP_EN defined: a valid mismatch in APPLY ends pattern application for that fault (TPG_EN=0 from the next cycle) and the state moves to DRAIN.
REQ-034 Macro MID_CTRL_FAULT_DROP_EN undefined: all PATS patterns are always applied per fault.

Verification
REQ-035 PATS=4, CUT_OP==FF_OP always, 3 faults (FIL_END high on the 3rd) -> 2 FIL_INC pulses, fault_cnt=3, det_cnt=0, done=1, TPG_EN high for 12 cycles.
REQ-036 PATS=4, mismatch only on pattern 4 of fault 2 -> det_cnt=1; the mismatch is caught during DRAIN.
REQ-037 PATS=1, 5 faults, every fault mismatching -> fault_cnt=5, det_cnt=5.
REQ-038 With MID_CTRL_FAULT_DROP_EN defined, PATS=8, mismatch on pattern 2 -> TPG_EN high for 3 cycles for that fault, det_cnt+1.
REQ-039 CNT_W=2, 6 faults all detected -> fault_cnt=3 and det_cnt=3 (saturated).
REQ-040 rst=0 in APPLY of fault 2 -> next cycle all outputs 0 and state IDLE; start then gives fault_cnt counting from 0.
